control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 143 ++++++++++++++
 tb/tb_control_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: instruction-cycle FSM for the core. Decodes the registered
// state into a one-hot state vector and the frame write enables, handles the
// memory ready handshakes for fetch and data access, and traps a memory
// timeout into a sticky FAULT state.
// Optional feature: define RETIRE_COUNT_EN to build the retired-instruction
// counter; without it instrRetired is tied to 0.
module control_sequencer #(
  parameter int MEM_WAIT_W   = 4,
  parameter int MAX_MEM_WAIT = 15,
  parameter int INSTR_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   stall,
  input  logic                   isLoad,
  input  logic                   isStore,
  input  logic                   memReady,
  output logic [6:0]             stateVec,
  output logic                   fetchReq,
  output logic                   memEnable,
  output logic                   decodeWe,
  output logic                   setupWe,
  output logic                   cir_writeEnable,
  output logic                   pc_writeEnable,
  output logic                   result_we,
  output logic                   memFault,
  output logic [INSTR_CNT_W-1:0] instrRetired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_REQ, S_FETCH_RECV, S_DECODE, S_SETUP,
    S_EXECUTE, S_MEM_READ, S_WRITEBACK, S_FAULT
  } state_t;

  localparam logic [MEM_WAIT_W-1:0] MAX_W = MEM_WAIT_W'(MAX_MEM_WAIT);

  state_t                state;
  logic [MEM_WAIT_W-1:0] wait_cnt;
  logic                  fault_q;
  logic                  mem_op;
  logic                  mem_wait;
  logic                  timeout;
  logic                  exec_exit;
  logic [INSTR_CNT_W-1:0] retire_cnt;

  assign mem_op    = isLoad | isStore;
  // States in which the sequencer is waiting on memReady
  assign mem_wait  = (state == S_FETCH_REQ) || ((state == S_EXECUTE) && mem_op);
  // Handshake takes priority over the timeout in the same cycle
  assign timeout   = mem_wait && !memReady && (wait_cnt == MAX_W);
  assign exec_exit = (state == S_EXECUTE) && (!mem_op || memReady);

  // State, wait counter and sticky fault; everything holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else if (!stall) begin
      case (state)
        S_IDLE: if (run) begin
          state    <= S_FETCH_REQ;
          wait_cnt <= '0;
        end
        S_FETCH_REQ: begin
          if (memReady)     state <= S_FETCH_RECV;
          else if (timeout) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else          wait_cnt <= wait_cnt + 1'b1;
        end
        S_FETCH_RECV: state <= S_DECODE;
        S_DECODE:     state <= S_SETUP;
        S_SETUP: begin
          state    <= S_EXECUTE;
          wait_cnt <= '0;
        end
        S_EXECUTE: begin
          if (!mem_op)      state <= S_WRITEBACK;
          else if (memReady) state <= isLoad ? S_MEM_READ : S_WRITEBACK;
          else if (timeout) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end else          wait_cnt <= wait_cnt + 1'b1;
        end
        S_MEM_READ: state <= S_WRITEBACK;
        S_WRITEBACK: begin
          if (run) begin
            state    <= S_FETCH_REQ;
            wait_cnt <= '0;
          end else state <= S_IDLE;
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RETIRE_COUNT_EN
  // Retired-instruction count, one per unstalled WRITEBACK cycle, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)                                 retire_cnt <= '0;
    else if (!stall && state == S_WRITEBACK)   retire_cnt <= retire_cnt + 1'b1;
  end
`else
  assign retire_cnt = '0;
`endif

  // Output decode from registered state; reset forces every output low so a
  // reset mid-instruction never leaks a partial enable
  always_comb begin
    stateVec        = '0;
    fetchReq        = 1'b0;
    memEnable       = 1'b0;
    cir_writeEnable = 1'b0;
    decodeWe        = 1'b0;
    setupWe         = 1'b0;
    pc_writeEnable  = 1'b0;
    result_we       = 1'b0;
    memFault        = 1'b0;
    instrRetired    = '0;
    if (!reset) begin
      stateVec[0]     = (state == S_FETCH_REQ);
      stateVec[1]     = (state == S_FETCH_RECV);
      stateVec[2]     = (state == S_DECODE);
      stateVec[3]     = (state == S_SETUP);
      stateVec[4]     = (state == S_EXECUTE);
      stateVec[5]     = (state == S_MEM_READ);
      stateVec[6]     = (state == S_WRITEBACK);
      fetchReq        = (state == S_FETCH_REQ);
      memEnable       = (state == S_EXECUTE) && mem_op;
      cir_writeEnable = !stall && (state == S_FETCH_RECV);
      decodeWe        = !stall && (state == S_DECODE);
      setupWe         = !stall && (state == S_SETUP);
      pc_writeEnable  = !stall && exec_exit;
      result_we       = !stall && (exec_exit || (state == S_MEM_READ));
      memFault        = fault_q;
      instrRetired    = retire_cnt;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: ALU, load, store, stalls, timeout
// boundary, fault and reset behaviour with hand-computed expectations.
module tb_control_sequencer;
  localparam int CW = 2;
`ifdef RETIRE_COUNT_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, run, stall, isLoad, isStore, memReady;
  logic [6:0] stateVec;
  logic fetchReq, memEnable, decodeWe, setupWe, cir_writeEnable;
  logic pc_writeEnable, result_we, memFault;
  logic [CW-1:0] instrRetired;
  logic [6:0] en_vec;
  int checks = 0;
  int errors = 0;
  int n_ret  = 0;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT_W(4), .MAX_MEM_WAIT(15), .INSTR_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .isLoad(isLoad),
    .isStore(isStore), .memReady(memReady), .stateVec(stateVec),
    .fetchReq(fetchReq), .memEnable(memEnable), .decodeWe(decodeWe),
    .setupWe(setupWe), .cir_writeEnable(cir_writeEnable),
    .pc_writeEnable(pc_writeEnable), .result_we(result_we),
    .memFault(memFault), .instrRetired(instrRetired)
  );

  // {fetchReq,memEnable,cir,decode,setup,pc,result}
  assign en_vec = {fetchReq, memEnable, cir_writeEnable, decodeWe, setupWe,
                   pc_writeEnable, result_we};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's state vector and enables, then advance a clock
  task automatic cyc(input string tag, input logic [6:0] sv, input logic [6:0] en);
    #1;
    chk({tag, " sv"}, {25'd0, stateVec}, {25'd0, sv});
    chk({tag, " en"}, {25'd0, en_vec}, {25'd0, en});
    @(posedge clk); #1;
  endtask

  task automatic chk_ret(input string tag);
    chk(tag, {30'd0, instrRetired}, RC ? (n_ret & 3) : 0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; stall = 1'b0; isLoad = 1'b0; isStore = 1'b0; memReady = 1'b1;
    #1;
    chk("rst cycle sv", {25'd0, stateVec}, 0);
    chk("rst cycle en", {25'd0, en_vec}, 0);
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0;
    cyc("post rst", 7'h00, 7'b0000000);
    chk("post rst fault", {31'd0, memFault}, 0);
    chk_ret("post rst retire");

    // ALU op, run held
    run = 1'b1;
    cyc("alu idle", 7'h00, 7'b0000000);
    cyc("alu freq", 7'h01, 7'b1000000);
    cyc("alu frcv", 7'h02, 7'b0010000);
    cyc("alu dec",  7'h04, 7'b0001000);
    cyc("alu set",  7'h08, 7'b0000100);
    cyc("alu exe",  7'h10, 7'b0000011);
    cyc("alu wb",   7'h40, 7'b0000000);
    n_ret++; chk_ret("alu retire");

    // Load with 3 wait cycles in EXECUTE
    isLoad = 1'b1;
    cyc("ld freq", 7'h01, 7'b1000000);
    cyc("ld frcv", 7'h02, 7'b0010000);
    cyc("ld dec",  7'h04, 7'b0001000);
    cyc("ld set",  7'h08, 7'b0000100);
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld wait", 7'h10, 7'b0100000);
    memReady = 1'b1;
    cyc("ld exe",  7'h10, 7'b0100011);
    cyc("ld mrd",  7'h20, 7'b0000001);
    cyc("ld wb",   7'h40, 7'b0000000);
    n_ret++; chk_ret("ld retire");

    // Store: stall in FETCH_REQ ignores memReady, stall 2 cycles in DECODE
    isLoad = 1'b0; isStore = 1'b1; stall = 1'b1;
    cyc("st freq stall", 7'h01, 7'b1000000);
    stall = 1'b0;
    cyc("st freq", 7'h01, 7'b1000000);
    cyc("st frcv", 7'h02, 7'b0010000);
    stall = 1'b1;
    cyc("st dec stall1", 7'h04, 7'b0000000);
    cyc("st dec stall2", 7'h04, 7'b0000000);
    stall = 1'b0;
    cyc("st dec", 7'h04, 7'b0001000);
    cyc("st set", 7'h08, 7'b0000100);
    cyc("st exe", 7'h10, 7'b0100011);
    // WRITEBACK with run=0 under stall holds, no retire
    run = 1'b0; stall = 1'b1;
    cyc("st wb stall1", 7'h40, 7'b0000000);
    cyc("st wb stall2", 7'h40, 7'b0000000);
    chk_ret("stall retire hold");
    stall = 1'b0;
    cyc("st wb", 7'h40, 7'b0000000);
    n_ret++; chk_ret("st retire");
    cyc("idle", 7'h00, 7'b0000000);

    // Handshake on the very cycle the counter reaches the limit: no fault
    isStore = 1'b0; run = 1'b1; memReady = 1'b0;
    cyc("bnd idle", 7'h00, 7'b0000000);
    for (int i = 0; i < 15; i++) cyc("bnd wait", 7'h01, 7'b1000000);
    memReady = 1'b1;
    cyc("bnd freq", 7'h01, 7'b1000000);
    cyc("bnd frcv", 7'h02, 7'b0010000);
    chk("bnd no fault", {31'd0, memFault}, 0);
    cyc("bnd dec", 7'h04, 7'b0001000);
    cyc("bnd set", 7'h08, 7'b0000100);
    cyc("bnd exe", 7'h10, 7'b0000011);
    cyc("bnd wb",  7'h40, 7'b0000000);
    n_ret++; chk_ret("bnd retire");
    n_ret++;

    // Fetch never acknowledged: fault after 16 cycles, sticky with run=1
    memReady = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to wait", 7'h01, 7'b1000000);
    chk("to fault", {31'd0, memFault}, 1);
    memReady = 1'b1;
    for (int i = 0; i < 3; i++) cyc("fault hold", 7'h00, 7'b0000000);
    chk("fault sticky", {31'd0, memFault}, 1);

    // Reset clears fault
    reset = 1'b1;
    #1;
    chk("rst2 fault", {31'd0, memFault}, 0);
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0;
    cyc("rst2 idle", 7'h00, 7'b0000000);
    chk("rst2 fault after", {31'd0, memFault}, 0);
    n_ret = 0; chk_ret("rst2 retire");

    // Reset in DECODE suppresses decodeWe
    run = 1'b1;
    cyc("mid idle", 7'h00, 7'b0000000);
    cyc("mid freq", 7'h01, 7'b1000000);
    cyc("mid frcv", 7'h02, 7'b0010000);
    reset = 1'b1;
    cyc("mid rst",  7'h00, 7'b0000000);
    reset = 1'b0; run = 1'b0;
    cyc("mid after", 7'h00, 7'b0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
